uart_burst_sequencer: RTL and testbench

// Drives a UART transmitter's load/send controls to transmit a burst of up to DEPTH queued bytes.
// It supports single-shot burst and auto-repeat modes, and passes manual load/send/data through when idle.

---
 rtl/uart_burst_sequencer.sv | 162 ++++++++++++++++
 tb/tb_uart_burst_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_burst_sequencer.sv
// rtl/uart_burst_sequencer.sv - sequences UART load/send controls for queued byte bursts
// All state advances only on baud_tick; tx_busy handshake marks each byte's completion.
module uart_burst_sequencer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int GAP_TICKS = 2,
  parameter int START_TMO = 4,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W:0]    burst_len,
  input  logic              man_load,
  input  logic              man_send,
  input  logic [DATA_W-1:0] man_data,
  input  logic              tx_busy,
  output logic              tx_load,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              busy,
  output logic              done,
  output logic              err_tmo
);

  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [IDX_W:0]   LEN_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_ADV, S_HOLD} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic [IDX_W:0]    len, len_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_nx;
  logic              err_nx, done_nx;
  logic              start_q;
  logic              start_edge;
  logic              last_byte;

  assign start_edge = start & ~start_q;
  assign last_byte  = ({1'b0, byte_idx} == (len - LEN_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      len      <= '0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      err_tmo  <= 1'b0;
      done     <= 1'b0;
      start_q  <= 1'b0;
    end else if (baud_tick) begin
      state    <= state_nx;
      byte_idx <= idx_nx;
      len      <= len_nx;
      tmo_cnt  <= tmo_nx;
      gap_cnt  <= gap_nx;
      err_tmo  <= err_nx;
      done     <= done_nx;
      start_q  <= start;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = byte_idx;
    len_nx   = len;
    tmo_nx   = tmo_cnt;
    gap_nx   = gap_cnt;
    err_nx   = err_tmo;
    done_nx  = 1'b0;
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge && mode != 2'b00 && burst_len != '0) begin
            len_nx   = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
            idx_nx   = '0;
            err_nx   = 1'b0;
            tmo_nx   = '0;
            state_nx = S_SEND;
          end
        end
        S_SEND: begin
          // A busy rise on the timeout tick still counts as a successful start.
          if (tx_busy) begin
            gap_nx   = '0;
            state_nx = S_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            err_nx   = 1'b1;
            state_nx = S_HOLD;
          end else begin
            tmo_nx = tmo_cnt + TMO_ONE;
          end
        end
        S_WAIT: begin
          if (tx_busy) begin
            gap_nx = '0;
          end else if (gap_cnt == GAP_LAST) begin
            gap_nx   = '0;
            state_nx = S_ADV;
          end else begin
            gap_nx = gap_cnt + GAP_ONE;
          end
        end
        S_ADV: begin
          tmo_nx = '0;
          if (last_byte) begin
            if (mode == 2'b10 && start) begin
              idx_nx   = '0;
              state_nx = S_SEND;
            end else begin
              done_nx  = 1'b1;
              state_nx = S_HOLD;
            end
          end else begin
            idx_nx   = byte_idx + IDX_ONE;
            state_nx = S_SEND;
          end
        end
        S_HOLD: begin
          // Held start button must be released before another burst can begin.
          if (!start) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_load = 1'b0;
    tx_send = 1'b0;
    tx_data = '0;
    case (state)
      S_IDLE: begin
        tx_load = man_load;
        tx_send = man_send;
        tx_data = man_data;
      end
      S_SEND:  tx_send = 1'b1;
      S_ADV:   tx_load = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_burst_sequencer.sv
// tb/tb_uart_burst_sequencer.sv - directed bench with transmitter model and byte_idx scoreboard
module tb_uart_burst_sequencer;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick = 1'b0;
  logic [1:0] mode;
  logic       start, abort;
  logic [2:0] burst_len;
  logic       man_load, man_send;
  logic [7:0] man_data;
  logic       tx_busy = 1'b0;
  logic       tx_load, tx_send;
  logic [7:0] tx_data;
  logic [1:0] byte_idx;
  logic       busy, done, err_tmo;

  int passed = 0;
  int total  = 0;
  int div = 0;
  int busy_cnt = 0;
  logic send_seen = 1'b0;
  logic prev_send = 1'b0;
  logic tx_en = 1'b0;
  int load_cnt = 0, send_cnt = 0, done_cnt = 0;
  int obs_q[$];
  int exp_q[$];
  int n;

  uart_burst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .mode(mode), .start(start),
    .abort(abort), .burst_len(burst_len), .man_load(man_load), .man_send(man_send),
    .man_data(man_data), .tx_busy(tx_busy), .tx_load(tx_load), .tx_send(tx_send),
    .tx_data(tx_data), .byte_idx(byte_idx), .busy(busy), .done(done), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // Tick strobe plus transmitter model: busy rises one tick after a send and lasts FRAME ticks.
  always @(negedge clk) begin
    if (div == 3) begin
      div = 0;
      baud_tick = 1'b1;
      if (!tx_en) begin
        busy_cnt = 0;
        send_seen = 1'b0;
      end else if (busy_cnt != 0) begin
        busy_cnt = busy_cnt - 1;
      end else if (send_seen) begin
        busy_cnt = FRAME;
        send_seen = 1'b0;
      end else if (tx_send) begin
        send_seen = 1'b1;
      end
      tx_busy = (busy_cnt != 0);
      if (tx_load && busy) begin
        obs_q.push_back(int'(byte_idx));
        load_cnt++;
      end
      if (tx_send && !prev_send) send_cnt++;
      prev_send = tx_send;
      if (done) done_cnt++;
    end else begin
      div++;
      baud_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic ticks(input int t);
    repeat (t * 4) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    load_cnt = 0;
    send_cnt = 0;
    done_cnt = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_sb(input string tag);
    int e, o;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_idx"}, o, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; start = 1'b0; abort = 1'b0; burst_len = 3'd0;
    man_load = 1'b0; man_send = 1'b0; man_data = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_tmo), 0);
    chk("rst_idx", int'(byte_idx), 0);
    chk("rst_tx", int'({tx_load, tx_send, tx_data}), 0);
    rst_n = 1'b1;
    ticks(2);

    // Manual pass-through
    man_data = 8'hA5; man_send = 1'b1;
    #1;
    chk("man_data", int'(tx_data), 'hA5);
    chk("man_send", int'(tx_send), 1);
    man_load = 1'b1;
    #1;
    chk("man_load", int'(tx_load), 1);
    start = 1'b1;
    ticks(3);
    chk("man_start_ignored", int'(busy), 0);
    start = 1'b0; man_load = 1'b0; man_send = 1'b0; man_data = 8'h00;
    ticks(2);

    // burst_len 0 is ignored
    mode = 2'b01; burst_len = 3'd0; start = 1'b1;
    ticks(3);
    chk("len0_ignored", int'(busy), 0);
    start = 1'b0;
    ticks(2);

    // Burst of 4
    clear_counts();
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    burst_len = 3'd4; start = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin @(posedge clk); #2; n++; end
    chk("burst_done_seen", done_cnt, 1);
    ticks(3);
    chk("burst_hold_busy", int'(busy), 1);
    chk("burst_hold_send", int'(tx_send), 0);
    chk("burst_sends", send_cnt, 4);
    chk("burst_loads", load_cnt, 4);
    chk("burst_done_once", done_cnt, 1);
    compare_sb("burst");
    start = 1'b0;
    ticks(2);
    chk("burst_idle", int'(busy), 0);

    // Repeat mode, release start after five bytes
    clear_counts();
    exp_q = '{0, 1, 0, 1, 0, 1};
    mode = 2'b10; burst_len = 3'd2; start = 1'b1;
    n = 0;
    while (load_cnt < 5 && n < 2000) begin @(posedge clk); #2; n++; end
    chk("rep_loads5", load_cnt, 5);
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin @(posedge clk); #2; n++; end
    chk("rep_done", done_cnt, 1);
    compare_sb("rep");
    ticks(2);
    chk("rep_idle", int'(busy), 0);

    // Start timeout with busy tied low
    clear_counts();
    tx_en = 1'b0;
    mode = 2'b01; burst_len = 3'd3; start = 1'b1;
    ticks(1);
    chk("tmo_in_send", int'(tx_send), 1);
    ticks(3);
    chk("tmo_not_yet", int'(err_tmo), 0);
    ticks(1);
    chk("tmo_err", int'(err_tmo), 1);
    chk("tmo_hold_busy", int'(busy), 1);
    chk("tmo_hold_send", int'(tx_send), 0);
    chk("tmo_no_loads", load_cnt, 0);
    start = 1'b0;
    ticks(2);
    chk("tmo_idle", int'(busy), 0);
    chk("tmo_sticky", int'(err_tmo), 1);

    // Abort during byte 2 WAIT
    clear_counts();
    tx_en = 1'b1;
    burst_len = 3'd4; start = 1'b1;
    ticks(1);
    chk("abort_err_cleared", int'(err_tmo), 0);
    n = 0;
    while (load_cnt < 2 && n < 2000) begin @(posedge clk); #2; n++; end
    n = 0;
    while (tx_busy !== 1'b1 && n < 200) begin @(posedge clk); #2; n++; end
    chk("abort_txbusy_rose", int'(tx_busy), 1);
    ticks(2);
    chk("abort_idx_before", int'(byte_idx), 2);
    abort = 1'b1;
    ticks(1);
    chk("abort_idle", int'(busy), 0);
    chk("abort_no_done", int'(done), 0);
    abort = 1'b0;
    ticks(20);
    chk("abort_idx_frozen", int'(byte_idx), 2);
    chk("abort_loads", load_cnt, 2);
    chk("abort_done_cnt", done_cnt, 0);
    start = 1'b0;
    ticks(12);

    // Fresh burst after abort, burst_len above DEPTH clamps to DEPTH
    clear_counts();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    burst_len = 3'd7; start = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin @(posedge clk); #2; n++; end
    chk("clamp_done", done_cnt, 1);
    chk("clamp_loads", load_cnt, 4);
    compare_sb("clamp");
    start = 1'b0;
    ticks(2);

    // Asynchronous reset mid-SEND
    burst_len = 3'd4; start = 1'b1;
    ticks(2);
    chk("rst_mid_send_pre", int'(tx_send), 1);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_tx", int'({tx_load, tx_send, tx_data}), 0);
    chk("rst_mid_idx", int'(byte_idx), 0);
    chk("rst_mid_err", int'(err_tmo), 0);
    start = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    ticks(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
